// File: rtl/apac_pkg.sv
// Shared types and constants for the APAC keypad front-end.
// Holds the entry FSM state encoding and the special key codes.
package apac_pkg;

    localparam int PIN_W = 8;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_D1 = 3'd1,
        WAIT_D2 = 3'd2,
        READY   = 3'd3,
        SUBMIT  = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/apac_key_edge.sv
// Keypad strobe edge detector: one-cycle edge on key_press rising, plus
// the key code captured on that edge (held afterwards for later readers).
module apac_key_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_key_code,
    input  logic       i_key_press,
    output logic       o_key_edge,
    output logic [3:0] o_key_code
);

    logic       r_key_q;
    logic [3:0] r_code;
    logic       w_edge;

    assign w_edge     = i_key_press & ~r_key_q;
    assign o_key_edge = w_edge;
    // Pass the live code in the edge cycle so the consumer sees it without delay.
    assign o_key_code = w_edge ? i_key_code : r_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_q <= 1'b0;
            r_code  <= 4'h0;
        end else begin
            r_key_q <= i_key_press;
            if (w_edge) begin
                r_code <= i_key_code;
            end
        end
    end

endmodule

// File: rtl/apac_pin_entry.sv
// Two-digit PIN entry FSM: collects digits, handles CLEAR/ENTER/timeout,
// and issues a TRY_WIDTH-cycle submit strobe with a stable PIN word.
module apac_pin_entry
    import apac_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TRY_WIDTH      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_code,
    input  logic             key_press,
    input  logic             sensor_1,
    input  logic             alarm_1,
    output logic [PIN_W-1:0] psswrd_atmpt,
    output logic             try_psswrd,
    output logic [1:0]       digit_count,
    output logic             entry_busy,
    output state_t           dbg_state
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam int SUB_W = (TRY_WIDTH > 1) ? $clog2(TRY_WIDTH) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TRY_WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [PIN_W-1:0] r_pin_buf;
    logic [PIN_W-1:0] r_psswrd;
    logic [TMO_W-1:0] r_tmo;
    logic [SUB_W-1:0] r_sub;
    logic             r_try;
    logic             r_busy;
    logic [1:0]       r_dc;
    logic             w_edge;
    logic [3:0]       w_code;
    logic             w_accept;
    logic             w_store_hi;
    logic             w_store_lo;
    logic             w_take;
    logic             w_try_nxt;
    logic             w_busy_nxt;
    logic [1:0]       w_dc_nxt;

    apac_key_edge u_key_edge (
        .clk         (clk),
        .rst         (rst),
        .i_key_code  (key_code),
        .i_key_press (key_press),
        .o_key_edge  (w_edge),
        .o_key_code  (w_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Priority: alarm, car gone, CLEAR, other keys, timeout.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_store_hi = 1'b0;
        w_store_lo = 1'b0;
        w_take     = 1'b0;
        if (alarm_1) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sensor_1) w_next = WAIT_D1;
                end
                WAIT_D1, WAIT_D2, READY: begin
                    if (!sensor_1) begin
                        w_next = IDLE;
                    end else if (w_edge && w_code == KEY_CLEAR) begin
                        w_next   = WAIT_D1;
                        w_accept = 1'b1;
                    end else if (w_edge && is_digit(w_code) && r_state == WAIT_D1) begin
                        w_next     = WAIT_D2;
                        w_store_hi = 1'b1;
                        w_accept   = 1'b1;
                    end else if (w_edge && is_digit(w_code) && r_state == WAIT_D2) begin
                        w_next     = READY;
                        w_store_lo = 1'b1;
                        w_accept   = 1'b1;
                    end else if (w_edge && w_code == KEY_ENTER && r_state == READY) begin
                        w_next   = SUBMIT;
                        w_take   = 1'b1;
                        w_accept = 1'b1;
                    end else if (r_state != WAIT_D1 && r_tmo == TMO_TERM) begin
                        w_next = WAIT_D1;
                    end
                end
                SUBMIT: begin
                    if (r_sub == SUB_LAST) w_next = sensor_1 ? WAIT_D1 : IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_try_nxt  = (w_next == SUBMIT);
        w_busy_nxt = (w_next == WAIT_D2) || (w_next == READY) || (w_next == SUBMIT);
        case (w_next)
            WAIT_D2:       w_dc_nxt = 2'd1;
            READY, SUBMIT: w_dc_nxt = 2'd2;
            default:       w_dc_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pin_buf <= '0;
            r_psswrd  <= '0;
            r_tmo     <= '0;
            r_sub     <= '0;
            r_try     <= 1'b0;
            r_busy    <= 1'b0;
            r_dc      <= 2'd0;
        end else begin
            if (w_next == IDLE || w_next == WAIT_D1) begin
                r_pin_buf <= '0;
            end else if (w_store_hi) begin
                r_pin_buf[7:4] <= w_code;
            end else if (w_store_lo) begin
                r_pin_buf[3:0] <= w_code;
            end
            if (w_take) r_psswrd <= r_pin_buf;
            // Timeout counter saturates at terminal until the state moves.
            if (w_next != r_state || w_accept) begin
                r_tmo <= '0;
            end else if ((r_state == WAIT_D2 || r_state == READY) && r_tmo != TMO_TERM) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_next != r_state) begin
                r_sub <= '0;
            end else if (r_state == SUBMIT && r_sub != SUB_LAST) begin
                r_sub <= r_sub + 1'b1;
            end
            r_try  <= w_try_nxt;
            r_busy <= w_busy_nxt;
            r_dc   <= w_dc_nxt;
        end
    end

    assign psswrd_atmpt = r_psswrd;
    assign try_psswrd   = r_try;
    assign digit_count  = r_dc;
    assign entry_busy   = r_busy;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_apac_pin_entry.sv
// Directed bench for apac_pin_entry: a per-cycle vector table for nominal and
// edited entry, then hand sequences for timeout, lockout, held key and reset.
module tb_apac_pin_entry;
    import apac_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_code = 4'h0;
    logic       key_press = 1'b0;
    logic       sensor_1 = 1'b0;
    logic       alarm_1 = 1'b0;
    logic [7:0] psswrd_atmpt;
    logic       try_psswrd;
    logic [1:0] digit_count;
    logic       entry_busy;
    state_t     dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    apac_pin_entry #(.TIMEOUT_CYCLES(10), .TRY_WIDTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_code     (key_code),
        .key_press    (key_press),
        .sensor_1     (sensor_1),
        .alarm_1      (alarm_1),
        .psswrd_atmpt (psswrd_atmpt),
        .try_psswrd   (try_psswrd),
        .digit_count  (digit_count),
        .entry_busy   (entry_busy),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] kc;
        logic       kp;
        logic       s1;
        logic       al;
        logic [2:0] st;
        logic [1:0] dc;
        logic       tr;
        logic       bs;
        logic [7:0] pw;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic [3:0] kc, input logic kp, input logic s1,
                                input logic al, input state_t st, input logic [1:0] dc,
                                input logic tr, input logic bs, input logic [7:0] pw);
        vec_t v;
        v.kc = kc; v.kp = kp; v.s1 = s1; v.al = al;
        v.st = st; v.dc = dc; v.tr = tr; v.bs = bs; v.pw = pw;
        return v;
    endfunction

    function automatic logic [15:0] pack(input logic [2:0] st, input logic [1:0] dc,
                                         input logic tr, input logic bs, input logic [7:0] pw);
        return {1'b0, st, dc, tr, bs, pw};
    endfunction

    function automatic logic [15:0] snap();
        return {1'b0, dbg_state, digit_count, try_psswrd, entry_busy, psswrd_atmpt};
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_code  = c;
        key_press = 1'b1;
        tick();
        key_press = 1'b0;
        tick();
    endtask

    // Scoreboard: every rising edge of try_psswrd must carry the next expected word.
    logic prev_try = 1'b0;
    always @(posedge clk) begin
        #2;
        if (try_psswrd && !prev_try) begin
            if (exp_q.size() == 0) begin
                chk("submit_unexpected", {8'h00, psswrd_atmpt}, 16'hFFFF);
            end else begin
                chk("submit_word", {8'h00, psswrd_atmpt}, {8'h00, exp_q.pop_front()});
            end
        end
        prev_try = try_psswrd;
    end

    initial begin
        vecs[0]  = mk(4'h0, 1'b0, 1'b1, 1'b0, WAIT_D1, 2'd0, 1'b0, 1'b0, 8'h00);
        vecs[1]  = mk(4'h5, 1'b1, 1'b1, 1'b0, WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h00);
        vecs[2]  = mk(4'h5, 1'b0, 1'b1, 1'b0, WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h00);
        vecs[3]  = mk(4'h7, 1'b1, 1'b1, 1'b0, READY,   2'd2, 1'b0, 1'b1, 8'h00);
        vecs[4]  = mk(4'h7, 1'b0, 1'b1, 1'b0, READY,   2'd2, 1'b0, 1'b1, 8'h00);
        vecs[5]  = mk(4'hB, 1'b1, 1'b1, 1'b0, SUBMIT,  2'd2, 1'b1, 1'b1, 8'h57);
        vecs[6]  = mk(4'hB, 1'b0, 1'b1, 1'b0, SUBMIT,  2'd2, 1'b1, 1'b1, 8'h57);
        vecs[7]  = mk(4'h0, 1'b0, 1'b1, 1'b0, WAIT_D1, 2'd0, 1'b0, 1'b0, 8'h57);
        vecs[8]  = mk(4'h5, 1'b1, 1'b1, 1'b0, WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h57);
        vecs[9]  = mk(4'h5, 1'b0, 1'b1, 1'b0, WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h57);
        vecs[10] = mk(4'hB, 1'b1, 1'b1, 1'b0, WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h57);
        vecs[11] = mk(4'hB, 1'b0, 1'b1, 1'b0, WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h57);
        vecs[12] = mk(4'hA, 1'b1, 1'b1, 1'b0, WAIT_D1, 2'd0, 1'b0, 1'b0, 8'h57);
        vecs[13] = mk(4'hA, 1'b0, 1'b1, 1'b0, WAIT_D1, 2'd0, 1'b0, 1'b0, 8'h57);
        vecs[14] = mk(4'h5, 1'b1, 1'b1, 1'b0, WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h57);
        vecs[15] = mk(4'h5, 1'b0, 1'b1, 1'b0, WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h57);
        vecs[16] = mk(4'hF, 1'b1, 1'b1, 1'b0, WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h57);
        vecs[17] = mk(4'hF, 1'b0, 1'b1, 1'b0, WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h57);
        vecs[18] = mk(4'h7, 1'b1, 1'b1, 1'b0, READY,   2'd2, 1'b0, 1'b1, 8'h57);
        vecs[19] = mk(4'h7, 1'b0, 1'b1, 1'b0, READY,   2'd2, 1'b0, 1'b1, 8'h57);
        vecs[20] = mk(4'h9, 1'b1, 1'b1, 1'b0, READY,   2'd2, 1'b0, 1'b1, 8'h57);
        vecs[21] = mk(4'h9, 1'b0, 1'b1, 1'b0, READY,   2'd2, 1'b0, 1'b1, 8'h57);
        vecs[22] = mk(4'hB, 1'b1, 1'b1, 1'b0, SUBMIT,  2'd2, 1'b1, 1'b1, 8'h57);
        vecs[23] = mk(4'hB, 1'b0, 1'b1, 1'b0, SUBMIT,  2'd2, 1'b1, 1'b1, 8'h57);
        vecs[24] = mk(4'h0, 1'b0, 1'b1, 1'b0, WAIT_D1, 2'd0, 1'b0, 1'b0, 8'h57);

        // Clock/reset
        tick();
        chk("reset_hold", snap(), pack(IDLE, 2'd0, 1'b0, 1'b0, 8'h00));
        tick();
        rst = 1'b0;
        tick();
        chk("reset_release", snap(), pack(IDLE, 2'd0, 1'b0, 1'b0, 8'h00));

        // Nominal entry and edited entry: exactly two submits of 8'h57.
        exp_q.push_back(8'h57);
        exp_q.push_back(8'h57);
        for (int i = 0; i < 25; i++) begin
            key_code  = vecs[i].kc;
            key_press = vecs[i].kp;
            sensor_1  = vecs[i].s1;
            alarm_1   = vecs[i].al;
            tick();
            chk($sformatf("vec%0d", i), snap(),
                pack(vecs[i].st, vecs[i].dc, vecs[i].tr, vecs[i].bs, vecs[i].pw));
        end

        // Timeout with one digit: still buffered on terminal cycle, gone after.
        press(4'h5);
        repeat (8) tick();
        chk("tmo_terminal_d2", snap(), pack(WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h57));
        tick();
        chk("tmo_expired_d2", snap(), pack(WAIT_D1, 2'd0, 1'b0, 1'b0, 8'h57));

        // Key on the terminal cycle wins over timeout.
        press(4'h5);
        repeat (8) tick();
        key_code  = 4'h7;
        key_press = 1'b1;
        tick();
        chk("tmo_key_wins", snap(), pack(READY, 2'd2, 1'b0, 1'b1, 8'h57));
        key_press = 1'b0;
        tick();
        repeat (8) tick();
        chk("tmo_terminal_ready", snap(), pack(READY, 2'd2, 1'b0, 1'b1, 8'h57));
        tick();
        chk("tmo_expired_ready", snap(), pack(WAIT_D1, 2'd0, 1'b0, 1'b0, 8'h57));

        // Lockout: alarm during SUBMIT aborts the pulse next cycle.
        press(4'h5);
        press(4'h9);
        exp_q.push_back(8'h59);
        key_code  = 4'hB;
        key_press = 1'b1;
        tick();
        chk("lock_submit", snap(), pack(SUBMIT, 2'd2, 1'b1, 1'b1, 8'h59));
        key_press = 1'b0;
        alarm_1   = 1'b1;
        tick();
        chk("lock_abort", snap(), pack(IDLE, 2'd0, 1'b0, 1'b0, 8'h59));
        press(4'h1);
        chk("lock_keys_ignored", snap(), pack(IDLE, 2'd0, 1'b0, 1'b0, 8'h59));
        alarm_1   = 1'b0;
        key_code  = 4'h3;
        key_press = 1'b1;
        tick();
        chk("unlock_edge_ignored", snap(), pack(WAIT_D1, 2'd0, 1'b0, 1'b0, 8'h59));
        key_press = 1'b0;
        tick();

        // Held key gives a single digit; then the car leaves in READY.
        key_code  = 4'h3;
        key_press = 1'b1;
        repeat (6) tick();
        chk("held_key", snap(), pack(WAIT_D2, 2'd1, 1'b0, 1'b1, 8'h59));
        key_press = 1'b0;
        tick();
        press(4'h4);
        chk("ready_before_leave", snap(), pack(READY, 2'd2, 1'b0, 1'b1, 8'h59));
        sensor_1 = 1'b0;
        tick();
        chk("car_left_ready", snap(), pack(IDLE, 2'd0, 1'b0, 1'b0, 8'h59));

        // Car leaves during SUBMIT: pulse still completes in full.
        sensor_1 = 1'b1;
        tick();
        press(4'h1);
        press(4'h2);
        exp_q.push_back(8'h12);
        key_code  = 4'hB;
        key_press = 1'b1;
        tick();
        chk("leave_submit_c1", snap(), pack(SUBMIT, 2'd2, 1'b1, 1'b1, 8'h12));
        key_press = 1'b0;
        sensor_1  = 1'b0;
        tick();
        chk("leave_submit_c2", snap(), pack(SUBMIT, 2'd2, 1'b1, 1'b1, 8'h12));
        tick();
        chk("leave_submit_end", snap(), pack(IDLE, 2'd0, 1'b0, 1'b0, 8'h12));

        // Asynchronous reset in the middle of SUBMIT.
        sensor_1 = 1'b1;
        tick();
        press(4'h6);
        press(4'h8);
        exp_q.push_back(8'h68);
        key_code  = 4'hB;
        key_press = 1'b1;
        tick();
        chk("rst_pre_submit", snap(), pack(SUBMIT, 2'd2, 1'b1, 1'b1, 8'h68));
        key_press = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_drop", snap(), pack(IDLE, 2'd0, 1'b0, 1'b0, 8'h00));
        tick();
        rst = 1'b0;
        tick();
        chk("rst_recover", snap(), pack(WAIT_D1, 2'd0, 1'b0, 1'b0, 8'h00));

        tick();
        chk("submits_drained", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
